// File: rtl/ahbl_sram_adapter.sv
// AHB-Lite subordinate driving a single-port active-low SRAM with zero wait states.
// A one-entry write buffer absorbs a write data phase that collides with a read address phase.
module ahbl_sram_adapter #(
  parameter int W_DATA = 32,
  parameter int DEPTH  = 512,
  localparam int W_SADDR = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ahbls_hready,
  output logic               ahbls_hready_resp,
  output logic               ahbls_hresp,
  input  logic [31:0]        ahbls_haddr,
  input  logic               ahbls_hwrite,
  input  logic [1:0]         ahbls_htrans,
  input  logic [2:0]         ahbls_hsize,
  input  logic [W_DATA-1:0]  ahbls_hwdata,
  output logic [W_DATA-1:0]  ahbls_hrdata,
  output logic               sram_cs_n,
  output logic               sram_we_n,
  output logic [3:0]         sram_be_n,
  output logic [W_SADDR-1:0] sram_addr,
  output logic [W_DATA-1:0]  sram_wdata,
  input  logic [W_DATA-1:0]  sram_rdata
);

  if (W_DATA != 32) begin : g_bad_width
    $fatal(1, "ahbl_sram_adapter: W_DATA must be 32");
  end

  localparam int NB = W_DATA / 8;

  logic               aph, rd_aph, wr_aph;
  logic [NB-1:0]      aph_be;
  logic [W_SADDR-1:0] aph_addr;

  logic               rd_dph_q, wr_dph_q, buf_valid_q;
  logic [W_SADDR-1:0] rd_addr_q, wr_addr_q, buf_addr_q;
  logic [NB-1:0]      rd_be_q, wr_be_q, buf_be_q;
  logic [W_DATA-1:0]  buf_data_q;

  logic               commit, retire, capture, fwd_hit;

  assign ahbls_hready_resp = 1'b1;
  assign ahbls_hresp       = 1'b0;

  // Reset also gates the address phase so the SRAM port goes quiet the instant rst_n falls.
  assign aph      = rst_n && ahbls_hready && ahbls_htrans[1];
  assign rd_aph   = aph && !ahbls_hwrite;
  assign wr_aph   = aph && ahbls_hwrite;
  assign aph_addr = ahbls_haddr[W_SADDR+1:2];

  always_comb begin
    aph_be = '1;
    case (ahbls_hsize[1:0])
      2'd0:    aph_be = 4'b0001 << ahbls_haddr[1:0];
      2'd1:    aph_be = ahbls_haddr[1] ? 4'b1100 : 4'b0011;
      default: aph_be = '1;
    endcase
  end

  assign commit  = wr_dph_q && !rd_aph;
  assign capture = wr_dph_q && rd_aph;
  assign retire  = buf_valid_q && !rd_aph && !wr_dph_q;

  always_comb begin
    sram_cs_n  = 1'b1;
    sram_we_n  = 1'b1;
    sram_be_n  = '1;
    sram_addr  = aph_addr;
    sram_wdata = buf_data_q;
    if (rd_aph) begin
      sram_cs_n = 1'b0;
      sram_be_n = '0;
    end else if (commit) begin
      sram_cs_n  = 1'b0;
      sram_we_n  = 1'b0;
      sram_addr  = wr_addr_q;
      sram_be_n  = ~wr_be_q;
      sram_wdata = ahbls_hwdata;
    end else if (retire) begin
      sram_cs_n = 1'b0;
      sram_we_n = 1'b0;
      sram_addr = buf_addr_q;
      sram_be_n = ~buf_be_q;
    end
  end

  // Bytes still sitting in the buffer are newer than the SRAM copy.
  assign fwd_hit = buf_valid_q && (buf_addr_q == rd_addr_q);

  always_comb begin
    ahbls_hrdata = '0;
    if (rd_dph_q) begin
      for (int i = 0; i < NB; i++) begin
        ahbls_hrdata[8*i +: 8] = (fwd_hit && buf_be_q[i]) ? buf_data_q[8*i +: 8]
                                                          : sram_rdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_dph_q    <= 1'b0;
      wr_dph_q    <= 1'b0;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      rd_be_q     <= '0;
      wr_be_q     <= '0;
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_be_q    <= '0;
      buf_data_q  <= '0;
    end else begin
      rd_dph_q <= rd_aph;
      wr_dph_q <= wr_aph;
      if (rd_aph) begin
        rd_addr_q <= aph_addr;
        rd_be_q   <= aph_be;
      end
      if (wr_aph) begin
        wr_addr_q <= aph_addr;
        wr_be_q   <= aph_be;
      end
      if (capture) begin
        buf_valid_q <= 1'b1;
        buf_addr_q  <= wr_addr_q;
        buf_be_q    <= wr_be_q;
        buf_data_q  <= ahbls_hwdata;
      end else if (retire) begin
        buf_valid_q <= 1'b0;
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{ahbls_haddr[31:W_SADDR+2], ahbls_htrans[0], ahbls_hsize[2], rd_be_q};

  // A write address phase always frees the port, so the buffer drains before the next write data phase.
  a_no_wr_into_full_buf: assert property (@(posedge clk) disable iff (!rst_n)
                                          !(wr_dph_q && buf_valid_q));

endmodule

// File: tb/tb_ahbl_sram_adapter.sv
// Directed bench for ahbl_sram_adapter with a behavioural single-port SRAM model.
module tb_ahbl_sram_adapter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ahbls_hready;
  logic        ahbls_hready_resp;
  logic        ahbls_hresp;
  logic [31:0] ahbls_haddr;
  logic        ahbls_hwrite;
  logic [1:0]  ahbls_htrans;
  logic [2:0]  ahbls_hsize;
  logic [31:0] ahbls_hwdata;
  logic [31:0] ahbls_hrdata;
  logic        sram_cs_n;
  logic        sram_we_n;
  logic [3:0]  sram_be_n;
  logic [8:0]  sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  logic        tb_init;
  logic [31:0] mem [0:511];
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  ahbl_sram_adapter #(.W_DATA(32), .DEPTH(512)) dut (
    .clk(clk), .rst_n(rst_n),
    .ahbls_hready(ahbls_hready), .ahbls_hready_resp(ahbls_hready_resp),
    .ahbls_hresp(ahbls_hresp), .ahbls_haddr(ahbls_haddr),
    .ahbls_hwrite(ahbls_hwrite), .ahbls_htrans(ahbls_htrans),
    .ahbls_hsize(ahbls_hsize), .ahbls_hwdata(ahbls_hwdata),
    .ahbls_hrdata(ahbls_hrdata), .sram_cs_n(sram_cs_n),
    .sram_we_n(sram_we_n), .sram_be_n(sram_be_n), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  // SRAM model: one-cycle read latency, byte-masked writes, preloaded with A5_0000_00 | index.
  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 512; i++) mem[i] <= 32'hA500_0000 | i;
      sram_rdata <= '0;
    end else if (!sram_cs_n) begin
      if (!sram_we_n) begin
        for (int b = 0; b < 4; b++)
          if (!sram_be_n[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One bus cycle: drive address phase (and write data for the previous write), then sit at negedge.
  task automatic step(input logic t, input logic w, input logic [31:0] a,
                      input logic [2:0] sz, input logic [31:0] wd, input logic rdy = 1'b1);
    @(posedge clk);
    #1;
    ahbls_htrans = t ? 2'b10 : 2'b00;
    ahbls_hwrite = w;
    ahbls_haddr  = a;
    ahbls_hsize  = sz;
    ahbls_hwdata = wd;
    ahbls_hready = rdy;
    @(negedge clk);
  endtask

  task automatic chk_wr(input string tag, input logic [8:0] a, input logic [3:0] ben,
                        input logic [31:0] d);
    chk({tag, "_cs"}, 32'(sram_cs_n), 32'd0);
    chk({tag, "_we"}, 32'(sram_we_n), 32'd0);
    chk({tag, "_be"}, 32'(sram_be_n), 32'(ben));
    chk({tag, "_addr"}, 32'(sram_addr), 32'(a));
    chk({tag, "_wdata"}, sram_wdata, d);
  endtask

  logic [31:0] d_k;

  initial begin
    rst_n = 1'b0; tb_init = 1'b1;
    ahbls_hready = 1'b1; ahbls_htrans = 2'b00; ahbls_hwrite = 1'b0;
    ahbls_haddr = '0; ahbls_hsize = 3'd2; ahbls_hwdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hready", 32'(ahbls_hready_resp), 32'd1);
    chk("rst_hresp", 32'(ahbls_hresp), 32'd0);
    chk("rst_hrdata", ahbls_hrdata, 32'd0);
    chk("rst_cs", 32'(sram_cs_n), 32'd1);
    chk("rst_we", 32'(sram_we_n), 32'd1);
    chk("rst_be", 32'(sram_be_n), 32'hf);
    @(posedge clk); #1;
    tb_init = 1'b0; rst_n = 1'b1;

    // Word write committed in its data phase, then read back
    step(1, 1, 32'h10, 3'd2, 32'h0);
    chk("t1_wr_aph_cs", 32'(sram_cs_n), 32'd1);
    step(0, 0, 32'h0, 3'd2, 32'hDEAD_BEEF);
    chk_wr("t1_commit", 9'h4, 4'h0, 32'hDEAD_BEEF);
    step(1, 0, 32'h10, 3'd2, 32'h0);
    chk("t1_rd_cs", 32'(sram_cs_n), 32'd0);
    chk("t1_rd_we", 32'(sram_we_n), 32'd1);
    chk("t1_rd_addr", 32'(sram_addr), 32'h4);
    step(0, 0, 32'h0, 3'd2, 32'h0);
    chk("t1_hrdata", ahbls_hrdata, 32'hDEAD_BEEF);
    chk("t1_hready", 32'(ahbls_hready_resp), 32'd1);

    // Write then read same address: buffered write forwarded over stale SRAM data
    step(1, 1, 32'h20, 3'd2, 32'h0);
    step(1, 0, 32'h20, 3'd2, 32'h1122_3344);
    chk("t2_rd_wins_we", 32'(sram_we_n), 32'd1);
    chk("t2_rd_addr", 32'(sram_addr), 32'h8);
    step(0, 0, 32'h0, 3'd2, 32'h0);
    chk("t2_old_rdata", sram_rdata, 32'hA500_0008);
    chk("t2_fwd", ahbls_hrdata, 32'h1122_3344);
    chk_wr("t2_retire", 9'h8, 4'h0, 32'h1122_3344);
    step(0, 0, 32'h0, 3'd2, 32'h0);
    chk("t2_mem", mem[8], 32'h1122_3344);

    // Partial byte forward
    step(1, 1, 32'h30, 3'd2, 32'h0);
    step(1, 1, 32'h31, 3'd0, 32'hAABB_CCDD);
    chk_wr("t3_word", 9'hC, 4'h0, 32'hAABB_CCDD);
    step(1, 0, 32'h30, 3'd2, 32'h0000_5500);
    step(0, 0, 32'h0, 3'd2, 32'h0);
    chk("t3_merge", ahbls_hrdata, 32'hAABB_55DD);
    chk_wr("t3_retire", 9'hC, 4'hD, 32'h0000_5500);
    step(0, 0, 32'h0, 3'd2, 32'h0);
    chk("t3_mem", mem[12], 32'hAABB_55DD);

    // Halfword enables on upper half
    step(1, 1, 32'h72, 3'd1, 32'h0);
    step(0, 0, 32'h0, 3'd2, 32'hBEEF_0000);
    chk_wr("t3h_half", 9'h1C, 4'h3, 32'hBEEF_0000);

    // Alternating W/R stream over 8 addresses, then full readback
    for (int k = 0; k < 8; k++) begin
      step(1, 1, 32'h100 + 4*k, 3'd2, 32'h0);
      chk("t4_hready", 32'(ahbls_hready_resp), 32'd1);
      if (k > 0) begin
        d_k = 32'hC0DE_0000 + k - 1;
        chk("t4_fwd", ahbls_hrdata, d_k);
      end
      step(1, 0, 32'h100 + 4*k, 3'd2, 32'hC0DE_0000 + k);
      chk("t4_hresp", 32'(ahbls_hresp), 32'd0);
    end
    step(0, 0, 32'h0, 3'd2, 32'h0);
    chk("t4_fwd_last", ahbls_hrdata, 32'hC0DE_0007);
    for (int k = 0; k < 8; k++) begin
      step(1, 0, 32'h100 + 4*k, 3'd2, 32'h0);
      if (k > 0) begin
        d_k = 32'hC0DE_0000 + k - 1;
        chk("t4_readback", ahbls_hrdata, d_k);
      end
    end
    step(0, 0, 32'h0, 3'd2, 32'h0);
    chk("t4_readback_last", ahbls_hrdata, 32'hC0DE_0007);

    // Read address phase stalled by hready low; buffered write retires meanwhile
    step(1, 1, 32'h40, 3'd2, 32'h0);
    step(1, 0, 32'h44, 3'd2, 32'h0BAD_F00D);
    step(1, 0, 32'h48, 3'd2, 32'h0, 1'b0);
    chk_wr("t5_retire", 9'h10, 4'h0, 32'h0BAD_F00D);
    chk("t5_rd44", ahbls_hrdata, 32'hA500_0011);
    step(1, 0, 32'h48, 3'd2, 32'h0, 1'b0);
    chk("t5_stall2_cs", 32'(sram_cs_n), 32'd1);
    step(1, 0, 32'h48, 3'd2, 32'h0, 1'b0);
    chk("t5_stall3_cs", 32'(sram_cs_n), 32'd1);
    step(1, 0, 32'h48, 3'd2, 32'h0, 1'b1);
    chk("t5_go_cs", 32'(sram_cs_n), 32'd0);
    chk("t5_go_addr", 32'(sram_addr), 32'h12);
    step(0, 0, 32'h0, 3'd2, 32'h0);
    chk("t5_rd48", ahbls_hrdata, 32'hA500_0012);
    chk("t5_mem", mem[16], 32'h0BAD_F00D);

    // Reset while the buffer holds a write: write must be discarded
    step(1, 1, 32'h50, 3'd2, 32'h0);
    step(1, 0, 32'h60, 3'd2, 32'hFEED_FACE);
    step(1, 0, 32'h64, 3'd2, 32'h0);
    chk("t6_pre_rd", ahbls_hrdata, 32'hA500_0018);
    @(posedge clk); #1;
    rst_n = 1'b0; ahbls_htrans = 2'b00;
    #1;
    chk("t6_rst_cs", 32'(sram_cs_n), 32'd1);
    chk("t6_rst_hrdata", ahbls_hrdata, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(0, 0, 32'h0, 3'd2, 32'h0);
    chk("t6_no_retire_cs", 32'(sram_cs_n), 32'd1);
    chk("t6_mem", mem[20], 32'hA500_0014);
    step(1, 0, 32'h50, 3'd2, 32'h0);
    step(0, 0, 32'h0, 3'd2, 32'h0);
    chk("t6_readback", ahbls_hrdata, 32'hA500_0014);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ahbl_sram_adapter.md
Name: ahbl_sram_adapter

Overview:
- AHB-Lite subordinate that acts as the initiator of the active-low single-port SRAM interface (cs_n/we_n/be_n, one-cycle read latency).
- Sits between the system AHB-Lite splitter and an SRAM array.
- Gives zero-wait-state reads and writes by holding a one-entry write buffer, with read-after-write forwarding.

Parameters:
- W_DATA, 32: bus and SRAM data width. Only 32 is supported; any other value is a $fatal at elaboration.
- DEPTH, 512: SRAM depth in words. W_SADDR = $clog2(DEPTH).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ahbls_hready  in  1  bus-wide HREADY
- ahbls_hready_resp  out  1  this subordinate's HREADYOUT
- ahbls_hresp  out  1  error response
- ahbls_haddr  in  32  byte address
- ahbls_hwrite  in  1  write when high
- ahbls_htrans  in  2  transfer type (the splitter already gates this for selection)
- ahbls_hsize  in  3  0 = byte, 1 = halfword, 2 = word
- ahbls_hwdata  in  32  write data, valid in data phase
- ahbls_hrdata  out  32  read data
- sram_cs_n  out  1  SRAM chip select, active low
- sram_we_n  out  1  SRAM write enable, active low
- sram_be_n  out  4  SRAM byte enables, active low
- sram_addr  out  W_SADDR  SRAM word address, taken from haddr[W_SADDR+1:2]
- sram_wdata  out  32  SRAM write data
- sram_rdata  in  32  SRAM read data, valid the cycle after a read strobe

Behaviour:
- Reset (async, rst_n low) forces:
  - ahbls_hready_resp = 1, ahbls_hresp = 0, ahbls_hrdata = 0.
  - sram_cs_n = 1, sram_we_n = 1, sram_be_n = 4'hf.
  - Write buffer invalid, data-phase flags clear.
  - Reset in mid-operation discards any buffered write.
- Outputs:
  - hready_resp is constant 1 and hresp is constant 0; every transfer completes with zero wait states.
  - Addresses alias modulo DEPTH*4 bytes.
- Address phase accept: aph = ahbls_hready && ahbls_htrans[1].
  - Byte enables come from hsize and haddr[1:0] in little-endian order:
    - byte: be = 1 << haddr[1:0]
    - halfword: be = 3 << {haddr[1],0}
    - word: be = 4'hf
- Read accept:
  - Same cycle: sram_cs_n = 0, sram_we_n = 1, sram_addr driven combinationally from haddr.
  - Registered state: rd_dph = 1, rd_addr, rd_be.
- Read data phase, the next cycle:
  - hrdata = sram_rdata, byte-merged with the buffer for each byte i where buf_valid && buf_addr == rd_addr && buf_be[i].
  - When rd_dph = 0, hrdata = 0.
- Write accept: register wr_dph = 1, wr_addr, wr_be. The SRAM is not used by the write address phase.
- Write data phase, the next cycle:
  - If no read aph this cycle: commit directly. sram_cs_n = 0, sram_we_n = 0, sram_addr = wr_addr, sram_be_n = ~wr_be, sram_wdata = hwdata.
  - Otherwise: capture {wr_addr, wr_be, hwdata} into the buffer at the clock edge and set buf_valid.
- Buffer retire:
  - Happens on any cycle with buf_valid and no read aph and no direct commit. The write is driven from the buffer and buf_valid clears.
  - A write aph always frees the SRAM port, so the buffer is always empty before the next write data phase. No stall path exists.
- Priority on the SRAM port, highest first: read aph, write data-phase commit, buffer retire. At most one access per cycle.
- Idle or busy htrans, or hready low (another subordinate stalling): no aph; the buffer may retire.
- Write data phase while buffer is valid: impossible by the above. An assertion covers this in simulation.

Test Plan:
- Word write 0x0000_0010 = 0xdeadbeef, then idle, then read 0x10 -> write committed in its data phase with sram_be_n = 0; read returns 0xdeadbeef.
- Back-to-back write 0x20 = 0x11223344 then read 0x20 -> buffer captures the write; hrdata = 0x11223344 by forwarding, with sram_rdata = old value.
- Word at 0x30 = 0xaabbccdd, then byte write 0x31 = 0x55 (hwdata 0x00005500) immediately followed by a read of 0x30 -> hrdata = 0xaabb55dd.
- Alternating W/R/W/R stream with 8 distinct addresses, no idle cycles -> hready_resp stays 1 throughout; final readback of all 8 matches; at most one SRAM strobe per cycle.
- Read aph held with ahbls_hready low for 3 cycles -> no SRAM strobe until hready is high; buffered write retires during the stall.
- Assert rst_n low with buf_valid = 1 -> sram_cs_n = 1 immediately; no retire after reset; SRAM location unchanged.
